// File: rtl/rv32c_fetch_sequencer_pkg.sv
// Shared types and helpers for the RV32C fetch sequencer.
package rv32c_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SPLIT = 2'd1,
    EMIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // Low two opcode bits that mark a full-width (non-compressed) instruction.
  localparam logic [1:0] RV32C_OPC_32 = 2'b11;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != RV32C_OPC_32;
  endfunction

endpackage

// File: rtl/rv32c_fetch_sequencer_if.sv
// imem read bus plus the instruction handshake toward decode.
interface rv32c_fetch_sequencer_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_raw;
  logic [31:0] inst_pc;
  logic        c_ena;

  // Sequencer side.
  modport master (
    output imem_ren, imem_addr, inst_valid, inst_raw, inst_pc, c_ena,
    input  imem_busy, imem_rdata, inst_ready
  );

  // Memory / decode side.
  modport slave (
    input  imem_ren, imem_addr, inst_valid, inst_raw, inst_pc, c_ena,
    output imem_busy, imem_rdata, inst_ready
  );
endinterface

// File: rtl/rv32c_fetch_sequencer_hwbuf.sv
// Holds the upper halfword of the last fetched word so a following
// halfword-aligned instruction can be served (or started) without a refetch.
module rv32c_halfword_buffer (
  input  logic        clk,
  input  logic        nrst,
  input  logic        flush_i,   // redirect: drop everything
  input  logic        clr_i,     // buffered halfword consumed or stale
  input  logic        load_i,    // capture a new upper halfword
  input  logic [15:0] ld_data_i,
  input  logic [29:0] ld_addr_i, // word address the halfword came from
  input  logic [31:1] pc_i,
  output logic [15:0] hw_buf_o,
  output logic        hw_valid_o,
  output logic        hit_o      // pc points at the buffered halfword
);
  logic [15:0] hw_buf_q;
  logic [29:0] hw_addr_q;
  logic        hw_valid_q;

  // Flush beats load beats clear; data/addr only move on load.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hw_buf_q   <= '0;
      hw_addr_q  <= '0;
      hw_valid_q <= 1'b0;
    end else if (flush_i) begin
      hw_valid_q <= 1'b0;
    end else if (load_i) begin
      hw_buf_q   <= ld_data_i;
      hw_addr_q  <= ld_addr_i;
      hw_valid_q <= 1'b1;
    end else if (clr_i) begin
      hw_valid_q <= 1'b0;
    end
  end

  assign hw_buf_o   = hw_buf_q;
  assign hw_valid_o = hw_valid_q;
  assign hit_o      = hw_valid_q && (hw_addr_q == pc_i[31:2]) && pc_i[1];
endmodule

// File: rtl/rv32c_fetch_sequencer.sv
// RV32C fetch sequencer: word-aligned imem reads, halfword instruction
// extraction, straddle stitching and one raw instruction per handshake.
module rv32c_fetch_sequencer
  import rv32c_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int          XLEN     = 32
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        c_enable,
  input  logic                        redirect,
  input  logic [31:0]                 redirect_pc,
  rv32c_fetch_sequencer_if.master     bus
);
  if (XLEN != 32) begin : g_xlen_chk
    $error("rv32c_fetch_sequencer supports XLEN=32 only");
  end

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [15:0]  hi_part_q;
  logic         imem_ren_q;
  logic [31:0]  imem_addr_q;
  logic         inst_valid_q;
  logic [31:0]  inst_raw_q;
  logic [31:0]  inst_pc_q;
  logic         c_ena_q;

  logic [15:0]  hw_buf;
  logic         hw_valid;
  logic         hw_hit;
  logic         hw_clr, hw_load;
  logic         unused_pc_bit0;

  logic [31:0]  w;
  logic         xfer, start, fetch_done, split_done, hit_c, hit_w;

  assign unused_pc_bit0 = redirect_pc[0];
  assign w          = bus.imem_rdata;
  assign xfer       = imem_ren_q && !bus.imem_busy;
  // A new fetch decision is taken either from an idle FETCH or in the same
  // cycle the emitted instruction is accepted, so the next request (or the
  // next buffered instruction) shows up on the very next cycle.
  assign start      = (state_q == FETCH && !imem_ren_q) ||
                      (state_q == EMIT && bus.inst_ready);
  assign fetch_done = (state_q == FETCH) && xfer;
  assign split_done = (state_q == SPLIT) && xfer;
  assign hit_c      = c_enable && hw_hit && is_compressed(hw_buf);
  assign hit_w      = c_enable && hw_hit && !is_compressed(hw_buf);

  // Halfword buffer control: load on a compressed low half or a completed
  // straddle, clear when its content is consumed or no longer applies.
  always_comb begin
    hw_load = 1'b0;
    hw_clr  = 1'b0;
    if (!redirect) begin
      if (start && hit_c) begin
        hw_clr = 1'b1;
      end else if (fetch_done) begin
        if (c_enable && !pc_q[1] && is_compressed(w[15:0])) hw_load = 1'b1;
        else                                                hw_clr  = 1'b1;
      end else if (split_done) begin
        hw_load = 1'b1;
      end
    end
  end

  rv32c_halfword_buffer u_hwbuf (
    .clk        (clk),
    .nrst       (nrst),
    .flush_i    (redirect),
    .clr_i      (hw_clr),
    .load_i     (hw_load),
    .ld_data_i  (w[31:16]),
    .ld_addr_i  (imem_addr_q[31:2]),
    .pc_i       (pc_q[31:1]),
    .hw_buf_o   (hw_buf),
    .hw_valid_o (hw_valid),
    .hit_o      (hw_hit)
  );

  // Fetch FSM with registered bus and instruction outputs; redirect wins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hi_part_q    <= '0;
      imem_ren_q   <= 1'b0;
      imem_addr_q  <= '0;
      inst_valid_q <= 1'b0;
      inst_raw_q   <= '0;
      inst_pc_q    <= '0;
      c_ena_q      <= 1'b0;
    end else if (redirect) begin
      pc_q         <= {redirect_pc[31:2], redirect_pc[1] & c_enable, 1'b0};
      inst_valid_q <= 1'b0;
      if (imem_ren_q && bus.imem_busy) begin
        state_q <= DRAIN;      // keep ren/addr until the old read retires
      end else begin
        state_q    <= FETCH;
        imem_ren_q <= 1'b0;
      end
    end else if (start) begin
      if (hit_c) begin
        inst_valid_q <= 1'b1;
        inst_raw_q   <= {16'h0, hw_buf};
        inst_pc_q    <= pc_q;
        c_ena_q      <= 1'b1;
        pc_q         <= pc_q + 32'd2;
        imem_ren_q   <= 1'b0;
        state_q      <= EMIT;
      end else if (hit_w) begin
        inst_valid_q <= 1'b0;
        hi_part_q    <= hw_buf;
        imem_ren_q   <= 1'b1;
        imem_addr_q  <= {pc_q[31:2] + 30'd1, 2'b00};
        state_q      <= SPLIT;
      end else begin
        inst_valid_q <= 1'b0;
        imem_ren_q   <= 1'b1;
        imem_addr_q  <= {pc_q[31:2], 2'b00};
        state_q      <= FETCH;
      end
    end else begin
      case (state_q)
        FETCH: if (xfer) begin
          inst_pc_q <= pc_q;
          if (!c_enable || (!pc_q[1] && !is_compressed(w[15:0]))) begin
            inst_valid_q <= 1'b1;
            inst_raw_q   <= w;
            c_ena_q      <= 1'b0;
            pc_q         <= pc_q + 32'd4;
            imem_ren_q   <= 1'b0;
            state_q      <= EMIT;
          end else if (!pc_q[1]) begin
            inst_valid_q <= 1'b1;
            inst_raw_q   <= {16'h0, w[15:0]};
            c_ena_q      <= 1'b1;
            pc_q         <= pc_q + 32'd2;
            imem_ren_q   <= 1'b0;
            state_q      <= EMIT;
          end else if (is_compressed(w[31:16])) begin
            inst_valid_q <= 1'b1;
            inst_raw_q   <= {16'h0, w[31:16]};
            c_ena_q      <= 1'b1;
            pc_q         <= pc_q + 32'd2;
            imem_ren_q   <= 1'b0;
            state_q      <= EMIT;
          end else begin
            // Upper half starts a 32-bit instruction: fetch the next word.
            hi_part_q   <= w[31:16];
            imem_addr_q <= {imem_addr_q[31:2] + 30'd1, 2'b00};
            state_q     <= SPLIT;
          end
        end
        SPLIT: if (xfer) begin
          inst_valid_q <= 1'b1;
          inst_raw_q   <= {w[15:0], hi_part_q};
          inst_pc_q    <= pc_q;
          c_ena_q      <= 1'b0;
          pc_q         <= pc_q + 32'd4;
          imem_ren_q   <= 1'b0;
          state_q      <= EMIT;
        end
        DRAIN: if (xfer) begin
          imem_ren_q <= 1'b0;
          state_q    <= FETCH;
        end
        default: ;             // EMIT holds until accepted
      endcase
    end
  end

  assign bus.imem_ren   = imem_ren_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_raw   = inst_raw_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.c_ena      = c_ena_q;
endmodule

// File: tb/tb_rv32c_fetch_sequencer.sv
// Directed bench for the RV32C fetch sequencer.
module tb_rv32c_fetch_sequencer;
  logic        clk;
  logic        nrst;
  logic        c_enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy_hold;
  logic        ready;
  logic [31:0] mem_w [0:511];
  int          errors = 0;
  int          checks = 0;
  int          reads  = 0;
  int          r0;

  rv32c_fetch_sequencer_if bus ();

  assign bus.imem_busy  = busy_hold;
  assign bus.imem_rdata = mem_w[bus.imem_addr[10:2]];
  assign bus.inst_ready = ready;

  rv32c_fetch_sequencer #(.RESET_PC(32'h0000_0200), .XLEN(32)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .c_enable    (c_enable),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count completed imem transfers.
  always @(posedge clk)
    if (nrst && bus.imem_ren && !bus.imem_busy) reads <= reads + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem_w[i] = 32'h0000_0013;
  endtask

  task automatic do_reset(input logic ce);
    c_enable = ce; redirect = 1'b0; redirect_pc = '0;
    busy_hold = 1'b0; ready = 1'b0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic wait_inst(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.inst_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $error("FAIL %s: observed no inst_valid expected inst_valid within 30 cycles", tag);
    end
  endtask

  task automatic accept();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic chk_inst(input string tag, input logic [31:0] raw,
                          input logic [31:0] pc, input logic ce);
    chk({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd1);
    chk({tag, "_raw"},   bus.inst_raw, raw);
    chk({tag, "_pc"},    bus.inst_pc, pc);
    chk({tag, "_c_ena"}, {31'd0, bus.c_ena}, {31'd0, ce});
  endtask

  initial begin
    clear_mem();
    // ---- Test 1 + 5: single 32-bit word, stall on inst_ready ----
    mem_w[9'h080] = 32'h00A0_0513;
    c_enable = 1'b1; redirect = 1'b0; redirect_pc = '0;
    busy_hold = 1'b0; ready = 1'b0; nrst = 1'b0;
    @(negedge clk);
    chk("rst_ren",   {31'd0, bus.imem_ren}, 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'd0);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_raw",   bus.inst_raw, 32'd0);
    chk("rst_pc",    bus.inst_pc, 32'd0);
    chk("rst_c_ena", {31'd0, bus.c_ena}, 32'd0);
    r0 = reads;
    nrst = 1'b1;
    @(negedge clk);
    chk("t1_ren",  {31'd0, bus.imem_ren}, 32'd1);
    chk("t1_addr", bus.imem_addr, 32'h200);
    wait_inst("t1_wait");
    chk_inst("t1", 32'h00A0_0513, 32'h200, 1'b0);
    chk("t1_reads", reads - r0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_inst("t5_hold", 32'h00A0_0513, 32'h200, 1'b0);
      chk("t5_no_ren", {31'd0, bus.imem_ren}, 32'd0);
    end
    accept();
    chk("t1_next_ren",  {31'd0, bus.imem_ren}, 32'd1);
    chk("t1_next_addr", bus.imem_addr, 32'h204);

    // ---- Test 2: two compressed halves, one read ----
    clear_mem();
    mem_w[9'h080] = 32'h4501_4501;
    do_reset(1'b1);
    r0 = reads;
    wait_inst("t2_wait");
    chk_inst("t2_a", 32'h0000_4501, 32'h200, 1'b1);
    accept();
    chk_inst("t2_b", 32'h0000_4501, 32'h202, 1'b1);
    chk("t2_reads", reads - r0, 32'd1);
    accept();
    chk("t2_next_ren",  {31'd0, bus.imem_ren}, 32'd1);
    chk("t2_next_addr", bus.imem_addr, 32'h204);
    chk("t2_reads2", reads - r0, 32'd1);

    // ---- Test 3: straddling 32-bit instruction ----
    clear_mem();
    mem_w[9'h080] = 32'h0513_4501;
    mem_w[9'h081] = 32'h4501_00A0;
    do_reset(1'b1);
    r0 = reads;
    wait_inst("t3_wait_a");
    chk_inst("t3_a", 32'h0000_4501, 32'h200, 1'b1);
    accept();
    chk("t3_split_addr", bus.imem_addr, 32'h204);
    wait_inst("t3_wait_b");
    chk_inst("t3_b", 32'h00A0_0513, 32'h202, 1'b0);
    chk("t3_reads_b", reads - r0, 32'd2);
    accept();
    chk_inst("t3_c", 32'h0000_4501, 32'h206, 1'b1);
    chk("t3_reads_c", reads - r0, 32'd2);
    accept();
    chk("t3_next_addr", bus.imem_addr, 32'h208);

    // ---- Test 4: redirect while a read is busy ----
    clear_mem();
    mem_w[9'h080] = 32'h00A0_0513;
    mem_w[9'h081] = 32'h4501_4501;
    mem_w[9'h0C0] = 32'h00B0_0593;
    do_reset(1'b1);
    wait_inst("t4_wait_a");
    busy_hold = 1'b1;
    accept();
    chk("t4_busy_addr", bus.imem_addr, 32'h204);
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    chk("t4_drain_ren",  {31'd0, bus.imem_ren}, 32'd1);
    chk("t4_drain_addr", bus.imem_addr, 32'h204);
    chk("t4_drain_valid", {31'd0, bus.inst_valid}, 32'd0);
    @(negedge clk);
    chk("t4_drain_valid2", {31'd0, bus.inst_valid}, 32'd0);
    busy_hold = 1'b0;
    @(negedge clk);
    chk("t4_after_valid", {31'd0, bus.inst_valid}, 32'd0);
    @(negedge clk);
    chk("t4_new_addr", bus.imem_addr, 32'h300);
    wait_inst("t4_wait_b");
    chk_inst("t4_b", 32'h00B0_0593, 32'h300, 1'b0);
    accept();

    // ---- Test 6: c_enable=0, word-only fetch ----
    clear_mem();
    mem_w[9'h080] = 32'h4501_4501;
    mem_w[9'h0C0] = 32'h00B0_0593;
    do_reset(1'b0);
    wait_inst("t6_wait_a");
    chk_inst("t6_a", 32'h4501_4501, 32'h200, 1'b0);
    accept();
    chk("t6_next_addr", bus.imem_addr, 32'h204);
    redirect = 1'b1; redirect_pc = 32'h302;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    chk("t6_redir_addr", bus.imem_addr, 32'h300);
    wait_inst("t6_wait_b");
    chk_inst("t6_b", 32'h00B0_0593, 32'h300, 1'b0);
    accept();

    // ---- Boundary: straddle across 0xFFFF_FFFE wraps to word 0 ----
    clear_mem();
    mem_w[9'h1FF] = 32'h0513_0001;
    mem_w[9'h000] = 32'h4501_00A0;
    do_reset(1'b1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    chk("wr_addr_a", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wr_addr_b", bus.imem_addr, 32'h0000_0000);
    wait_inst("wr_wait");
    chk_inst("wr_a", 32'h00A0_0513, 32'hFFFF_FFFE, 1'b0);
    accept();
    chk_inst("wr_b", 32'h0000_4501, 32'h0000_0002, 1'b1);
    accept();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
